// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 race-start controller.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HOLD,
        TIMING,
        DONE,
        JUMP
    } ctrl_state_t;

    localparam logic [6:0] LFSR_SEED = 7'h01;
    localparam logic [6:0] LFSR_TAPS = 7'b1100000;

    function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
        return {cur[5:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_7.sv
// Free-running 7-bit Fibonacci LFSR (x^7+x^6+1); never reaches zero from a non-zero seed.
module lfsr_7
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] q
);

    logic [6:0] q_q;
    logic [6:0] q_d;

    always_comb begin
        q_d = lfsr_next(q_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// Race-start controller: steps the lights sequencer on, holds for a random delay,
// turns the lights out and measures the driver's reaction time.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter int REACT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic               react,
    output logic               step_en,
    output logic               seq_rst,
    output logic [REACT_W-1:0] react_time,
    output logic               time_valid,
    output logic               false_start,
    output logic               busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [REACT_W-1:0] REACT_MAX  = '1;
    localparam logic [REACT_W-1:0] REACT_NEAR = {{(REACT_W-1){1'b1}}, 1'b0};

    ctrl_state_t        state_q, state_d;
    logic               trigger_q, react_q;
    logic [TW-1:0]      tick_q, tick_d;
    logic [3:0]         step_q, step_d;
    logic [6:0]         hold_q, hold_d;
    logic [REACT_W-1:0] count_q, count_d;
    logic [REACT_W-1:0] react_time_q, react_time_d;
    logic               seq_rst_q, seq_rst_d;
    logic               time_valid_q, time_valid_d;
    logic               false_start_q, false_start_d;
    logic               busy_q, busy_d;

    logic       trig_rise, react_rise;
    logic       tick_end, hold_end;
    logic [6:0] lfsr_q;

    lfsr_7 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign trig_rise  = trigger & ~trigger_q;
    assign react_rise = react & ~react_q;
    assign tick_end   = (tick_q == TICK_LAST);
    assign hold_end   = (state_q == HOLD) && tick_end && (hold_q == 7'd0);

    // A reaction in the final hold cycle wins, so the lights-out step is withheld.
    assign step_en = ((state_q == ARM) && tick_end) || (hold_end && !react_rise);

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_end ? '0 : tick_q + TW'(1);
        step_d       = step_q;
        hold_d       = hold_q;
        count_d      = count_q + REACT_W'(1);
        react_time_d = react_time_q;

        case (state_q)
            IDLE, DONE, JUMP: begin
                if (trig_rise) begin
                    state_d = ARM;
                    tick_d  = '0;
                    step_d  = 4'd0;
                end
            end
            ARM: begin
                if (react_rise) begin
                    state_d = JUMP;
                end else if (tick_end) begin
                    step_d = step_q + 4'd1;
                    if (step_q == 4'd7) begin
                        state_d = HOLD;
                        hold_d  = lfsr_q;
                    end
                end
            end
            HOLD: begin
                if (react_rise) begin
                    state_d = JUMP;
                end else if (tick_end) begin
                    if (hold_q == 7'd0) begin
                        state_d = TIMING;
                        count_d = '0;
                    end else begin
                        hold_d = hold_q - 7'd1;
                    end
                end
            end
            TIMING: begin
                if (react_rise) begin
                    state_d      = DONE;
                    react_time_d = count_q;
                end else if (count_q == REACT_NEAR) begin
                    state_d      = DONE;
                    react_time_d = REACT_MAX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        seq_rst_d     = state_d inside {IDLE, DONE, JUMP};
        busy_d        = state_d inside {ARM, HOLD, TIMING};
        time_valid_d  = (state_d == DONE);
        false_start_d = (state_d == JUMP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            trigger_q     <= 1'b0;
            react_q       <= 1'b0;
            tick_q        <= '0;
            step_q        <= 4'd0;
            hold_q        <= 7'd0;
            count_q       <= '0;
            react_time_q  <= '0;
            seq_rst_q     <= 1'b1;
            time_valid_q  <= 1'b0;
            false_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            trigger_q     <= trigger;
            react_q       <= react;
            tick_q        <= tick_d;
            step_q        <= step_d;
            hold_q        <= hold_d;
            count_q       <= count_d;
            react_time_q  <= react_time_d;
            seq_rst_q     <= seq_rst_d;
            time_valid_q  <= time_valid_d;
            false_start_q <= false_start_d;
            busy_q        <= busy_d;
        end
    end

    assign seq_rst     = seq_rst_q;
    assign react_time  = react_time_q;
    assign time_valid  = time_valid_q;
    assign false_start = false_start_q;
    assign busy        = busy_q;

endmodule
